// File: rtl/fetch_ctrl.sv
// Fetch controller: drives instruction memory and the IF/ID latch,
// parking a fetched word while decode stalls and flushing on redirect.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        latch_en,
  output logic [31:0] latch_instr,
  output logic [31:0] latch_pc,
  output logic [15:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= RESET_PC;
      cnt_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    cnt_d        = cnt_q;
    imem_req     = 1'b0;
    latch_en     = 1'b0;
    latch_instr  = NOP_INSTR;
    latch_pc     = pc_q;

    case (state_q)
      BOOT: begin
        latch_en = 1'b1;
        state_d  = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          pc_d = pc_q + 32'd4;
          if (!stall) begin
            latch_en    = 1'b1;
            latch_instr = imem_rdata;
            cnt_d       = cnt_q + 16'd1;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            state_d      = HOLD;
          end
        end else begin
          latch_en = !stall;
        end
      end
      HOLD: begin
        if (!stall) begin
          latch_en    = 1'b1;
          latch_instr = hold_instr_q;
          latch_pc    = hold_pc_q;
          cnt_d       = cnt_q + 16'd1;
          state_d     = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase

    // Flush wins over everything; any parked word is dropped.
    if (redirect) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      hold_instr_d = NOP_INSTR;
      cnt_d        = cnt_q;
      latch_en     = 1'b1;
      latch_instr  = NOP_INSTR;
      latch_pc     = pc_q;
      state_d      = FETCH;
    end
  end

  assign imem_addr = pc_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, fetch, stall/hold,
// bubbles, redirect, reset priority and pc wrap.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        latch_en;
  logic [31:0] latch_instr;
  logic [31:0] latch_pc;
  logic [15:0] fetch_cnt;

  logic [31:0] w_rdata;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_len;
  logic [31:0] w_instr;
  logic [31:0] w_lpc;
  logic [15:0] w_cnt;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'hA5A5_0000 ^ imem_addr;
  assign w_rdata    = 32'hA5A5_0000 ^ w_addr;

  fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .latch_en   (latch_en),
    .latch_instr(latch_instr),
    .latch_pc   (latch_pc),
    .fetch_cnt  (fetch_cnt)
  );

  fetch_ctrl #(
    .RESET_PC (32'hFFFF_FFFC),
    .NOP_INSTR(NOP)
  ) u_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_rdata (w_rdata),
    .imem_ready (imem_ready),
    .imem_req   (w_req),
    .imem_addr  (w_addr),
    .latch_en   (w_len),
    .latch_instr(w_instr),
    .latch_pc   (w_lpc),
    .fetch_cnt  (w_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    imem_ready  = 1'b1;
    tick();

    // Reset with redirect asserted: reset wins
    rst_n    = 1'b1;
    redirect = 1'b0;
    #1;
    check("boot_req", imem_req, 0);
    check("boot_addr", imem_addr, 32'h0);
    check("boot_len", latch_en, 1);
    check("boot_instr", latch_instr, NOP);
    check("boot_lpc", latch_pc, 32'h0);
    check("boot_cnt", fetch_cnt, 0);
    check("wrap_boot_addr", w_addr, 32'hFFFF_FFFC);
    tick();

    for (int i = 0; i < 2; i++) begin
      #1;
      check("f_req", imem_req, 1);
      check("f_len", latch_en, 1);
      check("f_instr", latch_instr, 32'hA5A5_0000 + 32'(4 * i));
      check("f_lpc", latch_pc, 32'(4 * i));
      tick();
      if (i == 0) check("wrap_addr", w_addr, 32'h0);
    end

    // Stall at pc=8 for three cycles
    stall = 1'b1;
    #1;
    check("st_len0", latch_en, 0);
    check("st_addr", imem_addr, 32'h8);
    tick();
    #1;
    check("hold_req", imem_req, 0);
    check("hold_len1", latch_en, 0);
    check("hold_addr", imem_addr, 32'hC);
    tick();
    #1;
    check("hold_len2", latch_en, 0);
    tick();
    stall = 1'b0;
    #1;
    check("rel_len", latch_en, 1);
    check("rel_instr", latch_instr, 32'hA5A5_0008);
    check("rel_lpc", latch_pc, 32'h8);
    tick();
    #1;
    check("post_addr", imem_addr, 32'hC);
    check("post_cnt", fetch_cnt, 3);
    check("post_instr", latch_instr, 32'hA5A5_000C);
    check("post_lpc", latch_pc, 32'hC);
    tick();
    check("cnt4", fetch_cnt, 4);
    check("addr10", imem_addr, 32'h10);

    // imem not ready: bubbles
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bub_len", latch_en, 1);
      check("bub_instr", latch_instr, NOP);
      check("bub_lpc", latch_pc, 32'h10);
      tick();
    end
    check("bub_addr", imem_addr, 32'h10);
    check("bub_cnt", fetch_cnt, 4);
    stall = 1'b1;
    #1;
    check("wait_stall_len", latch_en, 0);
    tick();
    check("wait_stall_addr", imem_addr, 32'h10);

    // Park word@10, then redirect from HOLD
    imem_ready = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check("rd_len", latch_en, 1);
    check("rd_instr", latch_instr, NOP);
    check("rd_lpc", latch_pc, 32'h14);
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    #1;
    check("rd_addr", imem_addr, 32'h100);
    check("rd_cnt", fetch_cnt, 4);
    check("rd_req", imem_req, 1);
    check("rd_finstr", latch_instr, 32'hA5A5_0100);
    check("rd_flpc", latch_pc, 32'h100);
    tick();
    check("rd_cnt5", fetch_cnt, 5);
    check("rd_addr104", imem_addr, 32'h104);

    // Reset while holding a word
    stall = 1'b1;
    tick();
    rst_n = 1'b0;
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("rh_addr", imem_addr, 32'h0);
    check("rh_cnt", fetch_cnt, 0);
    check("rh_len", latch_en, 1);
    check("rh_instr", latch_instr, NOP);
    tick();
    #1;
    check("rh_finstr", latch_instr, 32'hA5A5_0000);
    check("rh_flpc", latch_pc, 32'h0);
    tick();
    check("rh_cnt1", fetch_cnt, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
